// File: rtl/fast_pkg.sv
// Shared definitions for the FAST -> AXI4-Stream transmit path: word tags,
// field positions, FSM states and the byte-order helpers.
package fast_pkg;

  localparam int unsigned FAST_W  = 134;
  localparam int unsigned DATA_W  = 128;
  localparam int unsigned TAG_HI  = 133;
  localparam int unsigned TAG_LO  = 132;
  localparam int unsigned NINV_HI = 131;
  localparam int unsigned NINV_LO = 128;

  localparam logic [1:0] TAG_HEAD = 2'b01;
  localparam logic [1:0] TAG_MID  = 2'b11;
  localparam logic [1:0] TAG_TAIL = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_META,
    ST_SEND,
    ST_LAST,
    ST_DROP
  } tx_state_e;

  // FAST carries byte0 in the top byte; AXI carries byte0 in [7:0].
  function automatic logic [DATA_W-1:0] fast_to_axi_bytes(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      r[8*i +: 8] = d[DATA_W-1-8*i -: 8];
    end
    return r;
  endfunction

  function automatic logic [15:0] tail_keep(input logic [3:0] n_invalid);
    return 16'hFFFF >> n_invalid;
  endfunction

endpackage

// File: rtl/fast_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; a push on a
// full FIFO is accepted only when a pop frees a slot in the same cycle.
module fast_sync_fifo #(
  parameter int unsigned WIDTH = 134,
  parameter int unsigned DEPTH = 256,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full, do_push, do_pop;

  always_comb begin
    full     = (count_q == (AW+1)'(DEPTH));
    do_pop   = pop && (count_q != '0);
    do_push  = push && (!full || do_pop);
    wr_ptr_d = do_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is deliberately not reset; resetting the pointers and count
  // is enough to flush it and keeps the array mappable to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  assign rdata = mem[rd_ptr_q];
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/fast2axi_tx.sv
// Store-and-forward FAST (134b UM words) to 128b AXI4-Stream master: strips
// metadata words, reorders bytes, builds tkeep and discards dropped packets.
module fast2axi_tx
  import fast_pkg::*;
#(
  parameter int unsigned META_WORDS = 2,
  parameter int unsigned DATA_DEPTH = 256,
  parameter int unsigned PKT_DEPTH  = 16,
  parameter int unsigned MAX_PKT_WR = 134
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          in_data_wr,
  input  logic [133:0]  in_data,
  input  logic          in_valid_wr,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          m_axi_tvalid,
  output logic [127:0]  m_axi_tdata,
  output logic [15:0]   m_axi_tkeep,
  output logic [15:0]   m_axi_tstrb,
  output logic          m_axi_tlast,
  input  logic          m_axi_tready,
  output logic [31:0]   pkt_drop_cnt
);

  localparam int unsigned DAW = $clog2(DATA_DEPTH);
  localparam int unsigned PAW = $clog2(PKT_DEPTH);

  logic [FAST_W-1:0] d_rdata;
  logic              d_empty, d_pop;
  logic [DAW:0]      d_count;
  logic [0:0]        p_rdata;
  logic              p_empty, p_pop;
  logic [PAW:0]      p_count;

  fast_sync_fifo #(.WIDTH(FAST_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
    .clk(aclk), .rst(areset), .push(in_data_wr), .wdata(in_data),
    .pop(d_pop), .rdata(d_rdata), .empty(d_empty), .count(d_count)
  );

  fast_sync_fifo #(.WIDTH(1), .DEPTH(PKT_DEPTH)) u_pkt_fifo (
    .clk(aclk), .rst(areset), .push(in_valid_wr), .wdata(in_valid),
    .pop(p_pop), .rdata(p_rdata), .empty(p_empty), .count(p_count)
  );

  tx_state_e     state_q, state_d;
  logic [1:0]    meta_cnt_q, meta_cnt_d;
  logic          sent_q, sent_d;
  logic          out_valid_q, out_valid_d;
  logic [127:0]  out_data_q, out_data_d;
  logic [15:0]   out_keep_q, out_keep_d;
  logic          out_last_q, out_last_d;
  logic [31:0]   drop_cnt_q, drop_cnt_d;
  logic          in_ready_q, in_ready_d;
  logic [1:0]    tag;
  logic          is_tail, load;

  // NOTE: every signal gets a default first so no path through the case
  // statement leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d     = state_q;
    meta_cnt_d  = meta_cnt_q;
    sent_d      = sent_q;
    out_valid_d = out_valid_q && !m_axi_tready;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    drop_cnt_d  = drop_cnt_q;
    d_pop       = 1'b0;
    p_pop       = 1'b0;
    tag         = d_rdata[TAG_HI:TAG_LO];
    is_tail     = (tag == TAG_TAIL);
    load        = !out_valid_q || m_axi_tready;
    in_ready_d  = (d_count <= (DAW+1)'(DATA_DEPTH - MAX_PKT_WR)) &&
                  (p_count != (PAW+1)'(PKT_DEPTH));

    case (state_q)
      ST_IDLE: begin
        if (!p_empty) begin
          meta_cnt_d = '0;
          sent_d     = 1'b0;
          if (!p_rdata[0])          state_d = ST_DROP;
          else if (META_WORDS == 0) state_d = ST_SEND;
          else                      state_d = ST_META;
        end
      end
      ST_META: begin
        if (!d_empty) begin
          d_pop = 1'b1;
          // Tail inside the metadata means the packet has no payload at all.
          if (is_tail) begin
            p_pop      = 1'b1;
            drop_cnt_d = drop_cnt_q + 32'd1;
            state_d    = ST_IDLE;
          end else if (meta_cnt_q == 2'(META_WORDS - 1)) begin
            state_d = ST_SEND;
          end else begin
            meta_cnt_d = meta_cnt_q + 2'd1;
          end
        end
      end
      ST_SEND: begin
        if (load && !d_empty) begin
          if (tag == TAG_HEAD && (META_WORDS != 0 || sent_q)) begin
            state_d = ST_DROP;
          end else begin
            d_pop       = 1'b1;
            sent_d      = 1'b1;
            out_valid_d = 1'b1;
            out_data_d  = fast_to_axi_bytes(d_rdata[DATA_W-1:0]);
            out_keep_d  = is_tail ? tail_keep(d_rdata[NINV_HI:NINV_LO]) : 16'hFFFF;
            out_last_d  = is_tail;
            if (is_tail) state_d = ST_LAST;
          end
        end
      end
      ST_LAST: begin
        if (out_valid_q && out_last_q && m_axi_tready) begin
          p_pop   = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (!d_empty) begin
          d_pop = 1'b1;
          if (is_tail) begin
            p_pop      = 1'b1;
            drop_cnt_d = drop_cnt_q + 32'd1;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      meta_cnt_q  <= '0;
      sent_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_keep_q  <= '0;
      out_last_q  <= 1'b0;
      drop_cnt_q  <= '0;
      in_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      meta_cnt_q  <= meta_cnt_d;
      sent_q      <= sent_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      drop_cnt_q  <= drop_cnt_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign m_axi_tvalid = out_valid_q;
  assign m_axi_tdata  = out_data_q;
  assign m_axi_tkeep  = out_keep_q;
  assign m_axi_tstrb  = out_keep_q;
  assign m_axi_tlast  = out_last_q;
  assign pkt_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_fast2axi_tx.sv
// Scoreboard bench for fast2axi_tx: expected beats are queued as packets are
// written and compared by a monitor as the AXI stream hands them over.
module tb_fast2axi_tx;

  localparam int META = 2;
  localparam logic [1:0] HEAD = 2'b01;
  localparam logic [1:0] MID  = 2'b11;
  localparam logic [1:0] TAIL = 2'b10;

  typedef struct {
    logic [127:0] data;
    logic [15:0]  keep;
    logic         last;
  } beat_t;

  logic         aclk = 1'b0;
  logic         areset = 1'b1;
  logic         in_data_wr = 1'b0;
  logic [133:0] in_data = '0;
  logic         in_valid_wr = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic         m_axi_tvalid;
  logic [127:0] m_axi_tdata;
  logic [15:0]  m_axi_tkeep;
  logic [15:0]  m_axi_tstrb;
  logic         m_axi_tlast;
  logic         m_axi_tready = 1'b1;
  logic [31:0]  pkt_drop_cnt;

  int    checks = 0;
  int    failures = 0;
  beat_t sb[$];
  bit    mon_en = 1'b0;
  int    pkts_out = 0;
  logic [15:0] last_keep = '0;

  fast2axi_tx dut (
    .aclk(aclk), .areset(areset),
    .in_data_wr(in_data_wr), .in_data(in_data),
    .in_valid_wr(in_valid_wr), .in_valid(in_valid), .in_ready(in_ready),
    .m_axi_tvalid(m_axi_tvalid), .m_axi_tdata(m_axi_tdata),
    .m_axi_tkeep(m_axi_tkeep), .m_axi_tstrb(m_axi_tstrb),
    .m_axi_tlast(m_axi_tlast), .m_axi_tready(m_axi_tready),
    .pkt_drop_cnt(pkt_drop_cnt)
  );

  always #5 aclk = ~aclk;

  // Monitor: samples on the falling edge, between active edges.
  bit           stall = 1'b0;
  logic [127:0] held_data;
  logic [15:0]  held_keep;
  logic         held_last;

  always @(negedge aclk) begin
    if (!mon_en) begin
      stall = 1'b0;
    end else begin
      if (stall) begin
        checks++;
        if (m_axi_tvalid !== 1'b1 || m_axi_tdata !== held_data ||
            m_axi_tkeep !== held_keep || m_axi_tlast !== held_last) begin
          failures++;
          $display("FAIL stall_stable: valid=%b data=%h keep=%h last=%b required valid=1 data=%h keep=%h last=%b",
                   m_axi_tvalid, m_axi_tdata, m_axi_tkeep, m_axi_tlast, held_data, held_keep, held_last);
        end
      end
      if (m_axi_tvalid && m_axi_tready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_beat: data=%h keep=%h last=%b required no beat",
                   m_axi_tdata, m_axi_tkeep, m_axi_tlast);
        end else begin
          beat_t e;
          e = sb.pop_front();
          if (m_axi_tdata !== e.data || m_axi_tkeep !== e.keep ||
              m_axi_tstrb !== e.keep || m_axi_tlast !== e.last) begin
            failures++;
            $display("FAIL beat: data=%h keep=%h strb=%h last=%b required data=%h keep=%h last=%b",
                     m_axi_tdata, m_axi_tkeep, m_axi_tstrb, m_axi_tlast, e.data, e.keep, e.last);
          end
        end
        last_keep = m_axi_tkeep;
        if (m_axi_tlast) pkts_out++;
      end
      stall     = m_axi_tvalid && !m_axi_tready;
      held_data = m_axi_tdata;
      held_keep = m_axi_tkeep;
      held_last = m_axi_tlast;
    end
  end

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Writes an nwords-long packet (head, mids, tail); the flag goes with the
  // tail word (flag_dly=0) or flag_dly cycles after it.
  task automatic send_pkt(input int nwords, input int tail_n, input bit valid,
                          input int flag_dly, input logic [31:0] seed);
    for (int i = 0; i < nwords; i++) begin
      logic [31:0]  ii;
      logic [127:0] w;
      logic [1:0]   tg;
      beat_t        e;
      ii = i;
      w  = {seed ^ ii, seed + ii, ~seed ^ (ii << 8), ii ^ 32'hA5A5_0F0F};
      tg = (i == 0) ? HEAD : (i == nwords - 1) ? TAIL : MID;
      in_data_wr = 1'b1;
      in_data    = {tg, (i == nwords - 1) ? 4'(tail_n) : 4'h0, w};
      if (i == nwords - 1 && flag_dly == 0) begin
        in_valid_wr = 1'b1;
        in_valid    = valid;
      end
      if (valid && i >= META) begin
        for (int b = 0; b < 16; b++) e.data[8*b +: 8] = w[127-8*b -: 8];
        e.keep = (i == nwords - 1) ? (16'hFFFF >> tail_n) : 16'hFFFF;
        e.last = (i == nwords - 1);
        sb.push_back(e);
      end
      tick();
    end
    in_data_wr  = 1'b0;
    in_valid_wr = 1'b0;
    if (flag_dly > 0) begin
      repeat (flag_dly - 1) tick();
      in_valid_wr = 1'b1;
      in_valid    = valid;
      tick();
      in_valid_wr = 1'b0;
    end
  endtask

  task automatic wait_drain(input string name, input int budget, input bit toggle);
    int n;
    n = 0;
    while (!(sb.size() == 0 && !m_axi_tvalid) && n < budget) begin
      if (toggle) m_axi_tready = ~m_axi_tready;
      tick();
      n++;
    end
    m_axi_tready = 1'b1;
    checks++;
    if (n >= budget) begin
      failures++;
      $display("FAIL %s_drain_timeout: pending=%0d tvalid=%b required pending=0 tvalid=0",
               name, sb.size(), m_axi_tvalid);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({m_axi_tvalid, m_axi_tlast, m_axi_tkeep, m_axi_tstrb, in_ready} !== '0 ||
        m_axi_tdata !== '0 || pkt_drop_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_outputs: tvalid=%b tlast=%b tkeep=%h tdata=%h drop=%0d in_ready=%b required all 0",
               m_axi_tvalid, m_axi_tlast, m_axi_tkeep, m_axi_tdata, pkt_drop_cnt, in_ready);
    end
    areset = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_ready_early: in_ready=%b required 0", in_ready);
    end
    tick();
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_rise: in_ready=%b required 1", in_ready);
    end
    mon_en = 1'b1;
  endtask

  task automatic test_basic();
    int base;
    base = pkts_out;
    send_pkt(4, 6, 1'b1, 0, 32'h0011_2233);
    wait_drain("basic", 50, 1'b0);
    checks++;
    if (last_keep !== 16'h03FF || pkts_out - base !== 1) begin
      failures++;
      $display("FAIL basic_tail: keep=%h pkts=%0d required keep=03ff pkts=1", last_keep, pkts_out - base);
    end
  endtask

  task automatic test_drop();
    bit saw;
    saw = 1'b0;
    send_pkt(4, 6, 1'b0, 0, 32'h4455_6677);
    repeat (12) begin
      if (m_axi_tvalid) saw = 1'b1;
      tick();
    end
    checks++;
    if (saw !== 1'b0 || pkt_drop_cnt !== 32'd1) begin
      failures++;
      $display("FAIL drop: tvalid_seen=%b drop=%0d required tvalid_seen=0 drop=1", saw, pkt_drop_cnt);
    end
    send_pkt(5, 3, 1'b1, 0, 32'h8899_AABB);
    wait_drain("drop_next", 50, 1'b0);
  endtask

  task automatic test_malformed();
    send_pkt(2, 0, 1'b1, 0, 32'hDEAD_BEEF);
    repeat (10) tick();
    checks++;
    if (pkt_drop_cnt !== 32'd2 || m_axi_tvalid !== 1'b0) begin
      failures++;
      $display("FAIL malformed: drop=%0d tvalid=%b required drop=2 tvalid=0", pkt_drop_cnt, m_axi_tvalid);
    end
  endtask

  task automatic test_stall();
    int base;
    base = pkts_out;
    send_pkt(12, 9, 1'b1, 0, $urandom);
    wait_drain("stall", 100, 1'b1);
    checks++;
    if (pkts_out - base !== 1) begin
      failures++;
      $display("FAIL stall_pkts: got=%0d required 1", pkts_out - base);
    end
  endtask

  task automatic test_fill();
    int sent, base;
    sent = 0;
    base = pkts_out;
    m_axi_tready = 1'b0;
    while (in_ready && sent < 40) begin
      send_pkt(3, sent % 16, 1'b1, 0, $urandom);
      tick();
      tick();
      sent++;
    end
    checks++;
    if (in_ready !== 1'b0 || sent < 2) begin
      failures++;
      $display("FAIL fill_ready_low: in_ready=%b sent=%0d required in_ready=0", in_ready, sent);
    end
    m_axi_tready = 1'b1;
    wait_drain("fill", 400, 1'b0);
    tick();
    tick();
    checks++;
    if (pkts_out - base !== sent || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL fill_drain: out=%0d in_ready=%b required out=%0d in_ready=1",
               pkts_out - base, in_ready, sent);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    n = 0;
    m_axi_tready = 1'b0;
    send_pkt(12, 0, 1'b1, 0, $urandom);
    while (!m_axi_tvalid && n < 30) begin
      tick();
      n++;
    end
    checks++;
    if (m_axi_tvalid !== 1'b1) begin
      failures++;
      $display("FAIL reset_mid_start: tvalid=%b required 1", m_axi_tvalid);
    end
    mon_en = 1'b0;
    areset = 1'b1;
    tick();
    checks++;
    if (m_axi_tvalid !== 1'b0 || m_axi_tlast !== 1'b0 || pkt_drop_cnt !== 32'd0) begin
      failures++;
      $display("FAIL reset_mid: tvalid=%b tlast=%b drop=%0d required 0 0 0",
               m_axi_tvalid, m_axi_tlast, pkt_drop_cnt);
    end
    areset = 1'b0;
    sb.delete();
    m_axi_tready = 1'b1;
    mon_en = 1'b1;
    tick();
    tick();
    send_pkt(6, 5, 1'b1, 0, $urandom);
    wait_drain("reset_mid", 60, 1'b0);
  endtask

  task automatic test_flag_delay();
    logic [31:0] seed;
    seed = $urandom;
    send_pkt(5, 0, 1'b1, 0, seed);
    wait_drain("flag_now", 60, 1'b0);
    checks++;
    if (last_keep !== 16'hFFFF) begin
      failures++;
      $display("FAIL flag_now_keep: keep=%h required ffff", last_keep);
    end
    last_keep = '0;
    send_pkt(5, 0, 1'b1, 5, seed);
    wait_drain("flag_late", 60, 1'b0);
    checks++;
    if (last_keep !== 16'hFFFF) begin
      failures++;
      $display("FAIL flag_late_keep: keep=%h required ffff", last_keep);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_drop();
    test_malformed();
    test_stall();
    test_fill();
    test_reset_mid();
    test_flag_delay();
    repeat (3) tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL leftover_beats: pending=%0d required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
